// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by decode, operand fetch and execute.
//   DW / AW / OPW : data, register-address and operation-field widths
//   REG_ZERO      : hard-wired zero register number
//   OP_*          : operation codes shared between decode and EX
//   of_state_e    : operand-fetch stall state
//   sat_inc16     : 16-bit saturating increment
package cpu_pkg;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 5;
    localparam int unsigned OPW = 6;

    localparam logic [AW-1:0] REG_ZERO = '0;

    localparam logic [OPW-1:0] OP_NOP  = 6'd0;
    localparam logic [OPW-1:0] OP_ADD  = 6'd1;
    localparam logic [OPW-1:0] OP_SUB  = 6'd2;
    localparam logic [OPW-1:0] OP_AND  = 6'd3;
    localparam logic [OPW-1:0] OP_OR   = 6'd4;
    localparam logic [OPW-1:0] OP_XOR  = 6'd5;
    localparam logic [OPW-1:0] OP_SLL  = 6'd6;
    localparam logic [OPW-1:0] OP_SRL  = 6'd7;
    localparam logic [OPW-1:0] OP_LOAD = 6'd8;
    localparam logic [OPW-1:0] OP_STORE= 6'd9;
    localparam logic [OPW-1:0] OP_BEQ  = 6'd10;
    localparam logic [OPW-1:0] OP_JAL  = 6'd11;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } of_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// fwd_mux: priority select for one source operand.
//   rs              : source register number
//   rf_data         : register-file read data for rs
//   ex_we/ex_load   : EX writes rd / EX instruction is a load
//   ex_rd/ex_data   : EX destination and result
//   wb_we/wb_rd/wb_data : WB write port (lands at the end of this cycle)
//   data            : selected operand
// Priority: register zero -> rf_data; EX (non-load) -> ex_data;
// WB -> wb_data; otherwise rf_data.
module fwd_mux #(
    parameter int unsigned DW = cpu_pkg::DW,
    parameter int unsigned AW = cpu_pkg::AW
) (
    input  logic [AW-1:0] rs,
    input  logic [DW-1:0] rf_data,
    input  logic          ex_we,
    input  logic          ex_load,
    input  logic [AW-1:0] ex_rd,
    input  logic [DW-1:0] ex_data,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] data
);
    import cpu_pkg::*;

    always_comb begin
        data = rf_data;
        if (rs == AW'(REG_ZERO)) begin
            data = rf_data;
        end else if (ex_we && !ex_load && (ex_rd == rs)) begin
            data = ex_data;
        end else if (wb_we && (wb_rd == rs)) begin
            data = wb_data;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: decode/execute boundary stage.
// Reads both sources from the register file in the accept cycle, resolves
// RAW hazards by EX/WB bypass, stalls on load-use, and registers operands
// towards EX behind a valid/ready handshake.
//   CLK, reset (async, active-low)
//   in_*      : decoded instruction and handshake from decode
//   rf_a*     : register-file read addresses (combinational copies of rs)
//   rf_do*    : register-file read data (combinational)
//   ex_*/wb_* : bypass sources from EX and WB
//   flush     : discard held and incoming instruction
//   out_*     : registered operands and handshake to EX
//   stall_count : saturating count of load-use stall cycles
module operand_fetch #(
    parameter int unsigned DW  = cpu_pkg::DW,
    parameter int unsigned AW  = cpu_pkg::AW,
    parameter int unsigned OPW = cpu_pkg::OPW
) (
    input  logic           CLK,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [AW-1:0]  in_rs1,
    input  logic [AW-1:0]  in_rs2,
    input  logic [AW-1:0]  in_rd,
    input  logic [OPW-1:0] in_op,
    input  logic [DW-1:0]  in_imm,
    output logic [AW-1:0]  rf_a1,
    output logic [AW-1:0]  rf_a2,
    input  logic [DW-1:0]  rf_do1,
    input  logic [DW-1:0]  rf_do2,
    input  logic           ex_we,
    input  logic           ex_load,
    input  logic [AW-1:0]  ex_rd,
    input  logic [DW-1:0]  ex_data,
    input  logic           wb_we,
    input  logic [AW-1:0]  wb_rd,
    input  logic [DW-1:0]  wb_data,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OPW-1:0] out_op,
    output logic [AW-1:0]  out_rd,
    output logic [DW-1:0]  out_src1,
    output logic [DW-1:0]  out_src2,
    output logic [DW-1:0]  out_imm,
    output logic [15:0]    stall_count
);
    import cpu_pkg::*;

    of_state_e      state_q, state_d;
    logic           out_valid_q, out_valid_d;
    logic [OPW-1:0] out_op_q, out_op_d;
    logic [AW-1:0]  out_rd_q, out_rd_d;
    logic [DW-1:0]  out_src1_q, out_src1_d;
    logic [DW-1:0]  out_src2_q, out_src2_d;
    logic [DW-1:0]  out_imm_q, out_imm_d;
    logic [15:0]    stall_count_q, stall_count_d;

    logic [DW-1:0]  sel1, sel2;
    logic           hazard;
    logic           accept;

    assign rf_a1 = in_rs1;
    assign rf_a2 = in_rs2;

    fwd_mux #(.DW(DW), .AW(AW)) u_fwd1 (
        .rs      (in_rs1),
        .rf_data (rf_do1),
        .ex_we   (ex_we),
        .ex_load (ex_load),
        .ex_rd   (ex_rd),
        .ex_data (ex_data),
        .wb_we   (wb_we),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .data    (sel1)
    );

    fwd_mux #(.DW(DW), .AW(AW)) u_fwd2 (
        .rs      (in_rs2),
        .rf_data (rf_do2),
        .ex_we   (ex_we),
        .ex_load (ex_load),
        .ex_rd   (ex_rd),
        .ex_data (ex_data),
        .wb_we   (wb_we),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .data    (sel2)
    );

    // A load in EX has no data yet, so a consumer of its rd must wait a cycle.
    always_comb begin
        hazard = in_valid && ex_we && ex_load && (ex_rd != AW'(REG_ZERO)) &&
                 ((ex_rd == in_rs1) || (ex_rd == in_rs2));
    end

    assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        stall_count_d = stall_count_q;
        out_valid_d   = out_valid_q;
        out_op_d      = out_op_q;
        out_rd_d      = out_rd_q;
        out_src1_d    = out_src1_q;
        out_src2_d    = out_src2_q;
        out_imm_d     = out_imm_q;

        case (state_q)
            ST_RUN:   if (hazard && !flush) state_d = ST_STALL;
            ST_STALL: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        if (state_q == ST_STALL) begin
            stall_count_d = sat_inc16(stall_count_q);
        end

        // flush blocks accept via in_ready, so it only needs to clear valid.
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            out_op_d   = in_op;
            out_rd_d   = in_rd;
            out_src1_d = sel1;
            out_src2_d = sel2;
            out_imm_d  = in_imm;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            stall_count_q <= '0;
            out_valid_q   <= 1'b0;
            out_op_q      <= '0;
            out_rd_q      <= '0;
            out_src1_q    <= '0;
            out_src2_q    <= '0;
            out_imm_q     <= '0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
            out_valid_q   <= out_valid_d;
            out_op_q      <= out_op_d;
            out_rd_q      <= out_rd_d;
            out_src1_q    <= out_src1_d;
            out_src2_q    <= out_src2_d;
            out_imm_q     <= out_imm_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_op      = out_op_q;
    assign out_rd      = out_rd_q;
    assign out_src1    = out_src1_q;
    assign out_src2    = out_src2_q;
    assign out_imm     = out_imm_q;
    assign stall_count = stall_count_q;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

- Decode/execute boundary stage; sits directly downstream of `RegisterFile`.
- Each accepted instruction: drives the two source addresses to the register file and picks up `do1`/`do2` in the same cycle.
- Resolves read-after-write hazards by bypass from EX and WB, and stalls one cycle on load-use.
- Registers the operands with valid/ready handshakes on both sides for the execute stage.

## Interface
- `DW`, 32, data width (matches `RegisterFile`)
- `AW`, 5, register address width (32 registers)
- `OPW`, 6, decoded operation field width
- `CLK`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  decoded instruction present
- `in_ready`  out  1  stage accepts this cycle
- `in_rs1`, `in_rs2`, `in_rd`  in  AW  source and destination register numbers
- `in_op`  in  OPW  operation code, passed through
- `in_imm`  in  DW  immediate, passed through
- `rf_a1`, `rf_a2`  out  AW  to `RegisterFile` `a1`/`a2`; combinational copies of `in_rs1`/`in_rs2`
- `rf_do1`, `rf_do2`  in  DW  from `RegisterFile` `do1`/`do2` (combinational read)
- `ex_we`, `ex_load`  in  1  EX-stage instruction writes `rd`; it is a load
- `ex_rd`  in  AW  EX destination
- `ex_data`  in  DW  EX result (invalid when `ex_load`=1)
- `wb_we`  in  1  WB writes register file this edge (same signal as `RegisterFile` `we`)
- `wb_rd`  in  AW  WB destination (`ad`)
- `wb_data`  in  DW  WB data (`di`)
- `flush`  in  1  discard held and incoming instruction
- `out_valid`  out  1  operands valid to EX
- `out_ready`  in  1  EX accepts
- `out_op`  out  OPW  registered operation code
- `out_rd`  out  AW  registered destination
- `out_src1`, `out_src2`  out  DW  registered operands
- `out_imm`  out  DW  registered immediate
- `stall_count`  out  16  saturating count of load-use stall cycles

## Operation
- Per-source select, evaluated in priority order:
  1. Register 0 → `rf_doN`, never bypassed.
  2. `ex_we && !ex_load && ex_rd==rsN` → `ex_data`.
  3. `wb_we && wb_rd==rsN` → `wb_data`.
  4. Otherwise → `rf_doN`.
- `hazard` = `in_valid && ex_we && ex_load && ex_rd!=0 && (ex_rd==in_rs1 || ex_rd==in_rs2)`.
- `in_ready` = `!flush && !hazard && (!out_valid || out_ready)`.
- Accept (`in_valid && in_ready`): load the output registers from the select results and pass-throughs; `out_valid`←1.
- `out_valid && out_ready` with no accept → `out_valid`←0.
- `out_valid && !out_ready` → all outputs hold.
- `flush` → `out_valid`←0 next edge; output data registers hold; no accept that cycle, whatever `in_valid`.
- State: `RUN` (default) and `STALL`.
  - `RUN` → `STALL` when `hazard && !flush`.
  - `STALL` → `RUN` on the next edge, unconditionally; EX has by then advanced the load.
  - `hazard` re-evaluates each cycle.
- `stall_count` increments each cycle in `STALL`; saturates at 16'hFFFF.

## Timing
- Reset (`reset`=0, async): `out_valid`=0; `out_op`, `out_rd`, `out_src1`, `out_src2`, `out_imm`=0; `stall_count`=0; state `RUN`. Any in-flight instruction is lost.
- Latency: accept at edge N → `out_valid`=1 and data stable after edge N.
- Throughput: one instruction per cycle when `out_ready`=1 and no hazard.
- Each load-use costs exactly one bubble.
- `rf_a1`/`rf_a2` have no register; the `RegisterFile` read path is in the same cycle as the select mux.
- WB bypass is required because a `RegisterFile` write lands at the edge that ends the read cycle.
- Simultaneous EX and WB match on the same rs: EX wins.
- Simultaneous `flush` and `hazard`: flush wins; no transition to `STALL`.
- `flush` while `out_valid && !out_ready`: held entry is discarded.

## Structure
- Shared package `cpu_pkg`:
  - `DW`, `AW`, `OPW`
  - `REG_ZERO`=0
  - operation-code constants shared with decode and EX
- One sub-module: `fwd_mux`, the per-operand priority select.
  - Inputs: rs, rf data, EX/WB bypass signals.
  - Instantiated twice.

## Test plan
- Preload: `RegisterFile` holds reg[k]=10*k.
  - Stimulus: rs1=3, rs2=4, no bypass.
  - Response: one cycle later `out_src1`=30, `out_src2`=40, `out_valid`=1.
- EX bypass:
  - Stimulus: `ex_we`=1, `ex_rd`=3, `ex_data`=777, rs1=3.
  - Response: `out_src1`=777.
  - Repeat with `wb_we`=1, `wb_rd`=3, `wb_data`=555 also asserted → `out_src1`=777 (EX wins).
  - WB only → 555.
- Register 0:
  - Stimulus: rs1=0 with `ex_rd`=0, `ex_data`=99, `ex_we`=1.
  - Response: `out_src1`=`rf_do1`=0.
- Load-use:
  - Stimulus: `ex_load`=1, `ex_rd`=5, rs2=5.
  - Response: `in_ready`=0 for exactly one cycle; `stall_count` 0→1.
  - Next cycle with `ex_we`=0, `wb_we`=1, `wb_rd`=5, `wb_data`=123 → `out_src2`=123.
- Backpressure and flush:
  - `out_ready`=0 for 3 cycles → outputs hold and `in_ready`=0.
  - `flush` pulse → `out_valid`=0 next cycle.
- Reset mid-operation:
  - Stimulus: `reset` low asynchronously while `out_valid`=1 in `STALL`.
  - Response: all outputs 0 immediately, without waiting for an edge; state `RUN`.
